// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requests, register-file write port and forwarding lookups
interface regfile_wb_arbiter_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic                     req1_valid;
    logic [ADDRESS_WIDTH-1:0] req1_rd;
    logic [DATA_WIDTH-1:0]    req1_data;
    logic                     req2_valid;
    logic [ADDRESS_WIDTH-1:0] req2_rd;
    logic [DATA_WIDTH-1:0]    req2_data;
    logic                     stall;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic [ADDRESS_WIDTH-1:0] chk1_addr;
    logic [ADDRESS_WIDTH-1:0] chk2_addr;
    logic                     chk1_hit;
    logic                     chk2_hit;
    logic [DATA_WIDTH-1:0]    chk1_data;
    logic [DATA_WIDTH-1:0]    chk2_data;

    modport master (
        output req1_valid, req1_rd, req1_data, req2_valid, req2_rd, req2_data, chk1_addr, chk2_addr,
        input  stall, wr_en, wr_addr, wr_data, chk1_hit, chk2_hit, chk1_data, chk2_data
    );
    modport slave (
        input  req1_valid, req1_rd, req1_data, req2_valid, req2_rd, req2_data, chk1_addr, chk2_addr,
        output stall, wr_en, wr_addr, wr_data, chk1_hit, chk2_hit, chk1_data, chk2_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: serialises dual-issue writebacks through a FIFO onto one write port
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input logic              clk,
    input logic              rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [PW-1:0]            head, tail;
    logic [CW-1:0]            count, enq_n;
    logic                     busy, take1, take2;

    assign busy      = count != '0;
    assign bus.stall = count > CW'(DEPTH - 2);
    assign take1     = !bus.stall && bus.req1_valid && bus.req1_rd != '0;
    assign take2     = !bus.stall && bus.req2_valid && bus.req2_rd != '0;
    assign enq_n     = CW'(take1) + CW'(take2);

    assign bus.wr_en   = busy;
    assign bus.wr_addr = busy ? rd_q[head] : '0;
    assign bus.wr_data = busy ? data_q[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(busy);
            tail  <= tail + enq_n[PW-1:0];
            count <= count + enq_n - CW'(busy);
        end
    end

    // req2 lands behind req1 so it is written last and wins on a shared rd
    always_ff @(posedge clk) begin
        if (take1) begin
            rd_q[tail]   <= bus.req1_rd;
            data_q[tail] <= bus.req1_data;
        end
        if (take2) begin
            rd_q[take1 ? tail + PW'(1) : tail]   <= bus.req2_rd;
            data_q[take1 ? tail + PW'(1) : tail] <= bus.req2_data;
        end
    end

    // scan oldest to youngest so the last match is the youngest pending value
    always_comb begin
        bus.chk1_hit  = 1'b0;
        bus.chk1_data = '0;
        bus.chk2_hit  = 1'b0;
        bus.chk2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && bus.chk1_addr != '0 && rd_q[head + PW'(i)] == bus.chk1_addr) begin
                bus.chk1_hit  = 1'b1;
                bus.chk1_data = data_q[head + PW'(i)];
            end
            if (CW'(i) < count && bus.chk2_addr != '0 && rd_q[head + PW'(i)] == bus.chk2_addr) begin
                bus.chk2_hit  = 1'b1;
                bus.chk2_data = data_q[head + PW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors plus a queue scoreboard of pending writes
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [36:0] mq[$];

    regfile_wb_arbiter_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) bus ();
    regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] r2, input logic [31:0] d2);
        bus.req1_valid = v1; bus.req1_rd = r1; bus.req1_data = d1;
        bus.req2_valid = v2; bus.req2_rd = r2; bus.req2_data = d2;
    endtask

    function automatic logic [32:0] youngest(input logic [4:0] a);
        logic [32:0] r = '0;
        foreach (mq[i]) if (a != 0 && mq[i][36:32] == a) r = {1'b1, mq[i][31:0]};
        return r;
    endfunction

    // models the next edge from the inputs presented now, then checks all outputs
    task automatic tick();
        bit acc = mq.size() <= 2;
        bit ne  = mq.size() > 0;
        logic [36:0] hd;
        logic [32:0] l1, l2;
        if (acc && bus.req1_valid && bus.req1_rd != 0) mq.push_back({bus.req1_rd, bus.req1_data});
        if (acc && bus.req2_valid && bus.req2_rd != 0) mq.push_back({bus.req2_rd, bus.req2_data});
        if (ne) void'(mq.pop_front());
        @(posedge clk);
        #1;
        hd = mq.size() > 0 ? mq[0] : '0;
        l1 = youngest(bus.chk1_addr);
        l2 = youngest(bus.chk2_addr);
        check("m_wr_en", bus.wr_en, mq.size() > 0);
        check("m_wr_addr", bus.wr_addr, hd[36:32]);
        check("m_wr_data", bus.wr_data, hd[31:0]);
        check("m_stall", bus.stall, mq.size() > 2);
        check("m_chk1", {bus.chk1_hit, bus.chk1_data}, l1);
        check("m_chk2", {bus.chk2_hit, bus.chk2_data}, l2);
    endtask

    initial begin
        bit saw_stall = 0;
        int issued = 0;
        drive(0, 0, 0, 0, 0, 0);
        bus.chk1_addr = 5'd0;
        bus.chk2_addr = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_hit", bus.chk1_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.chk1_addr = 5'd5;
        repeat (3) begin
            tick();
            check("idle_wr_en", bus.wr_en, 0);
            check("idle_hit", bus.chk1_hit, 0);
        end

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("single_en", bus.wr_en, 1);
        check("single_addr", bus.wr_addr, 5);
        check("single_data", bus.wr_data, 32'hDEADBEEF);
        check("single_fwd", {bus.chk1_hit, bus.chk1_data}, {1'b1, 32'hDEADBEEF});
        tick();
        check("single_done", bus.wr_en, 0);

        bus.chk1_addr = 5'd7;
        drive(1, 7, 32'h11, 1, 7, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("same_w1", bus.wr_data, 32'h11);
        check("same_fwd1", {bus.chk1_hit, bus.chk1_data}, {1'b1, 32'h22});
        tick();
        check("same_w2", bus.wr_data, 32'h22);
        check("same_fwd2", {bus.chk1_hit, bus.chk1_data}, {1'b1, 32'h22});
        tick();
        check("same_done", bus.wr_en, 0);

        bus.chk1_addr = 5'd3;
        bus.chk2_addr = 5'd0;
        drive(1, 0, 32'hFF, 1, 3, 32'h33);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("x0_addr", bus.wr_addr, 3);
        check("x0_data", bus.wr_data, 32'h33);
        check("x0_chk0", bus.chk2_hit, 0);
        tick();
        check("x0_once", bus.wr_en, 0);

        bus.chk1_addr = 5'd4;
        bus.chk2_addr = 5'd9;
        for (int c = 0; c < 40 && (issued < 10 || mq.size() > 0); c++) begin
            saw_stall |= bus.stall;
            if (bus.stall) drive(1, 31, 32'hBAD, 1, 31, 32'hBAD);
            else if (issued < 10) begin
                drive(1, 5'(2 * issued + 1), 32'h100 + 2 * issued, 1, 5'(2 * issued + 2), 32'h101 + 2 * issued);
                issued++;
            end else drive(0, 0, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("bp_saw_stall", saw_stall, 1);
        check("bp_issued", issued, 10);
        check("bp_drained", mq.size(), 0);

        bus.chk1_addr = 5'd11;
        bus.chk2_addr = 5'd12;
        drive(1, 9, 32'hA1, 1, 10, 32'hA2);
        tick();
        drive(1, 11, 32'hA3, 1, 12, 32'hA4);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("mid_stall", bus.stall, 1);
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        check("mid_wr_en", bus.wr_en, 0);
        check("mid_wr_addr", bus.wr_addr, 0);
        check("mid_wr_data", bus.wr_data, 0);
        check("mid_stall0", bus.stall, 0);
        check("mid_chk1", {bus.chk1_hit, bus.chk1_data}, 33'h0);
        check("mid_chk2", {bus.chk2_hit, bus.chk2_data}, 33'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("post_wr_en", bus.wr_en, 0);
            check("post_hit", bus.chk1_hit, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
